prog_loader: RTL and testbench
==============================

# prog_loader

Program loader and run controller for one `proc` core. It accepts a program as a stream of 32-bit words and assembles each group of words into one full-width command. It writes each command into the core's command memory through the core's `write_prog_enable`/`cmd_addr`/`cmd_data` port. It holds the core in reset while loading and releases it only on an explicit run request.

## Interface
Parameters:
- `CMD_WIDTH`, 128: command width; must be an integer multiple of `WORD_WIDTH`.
- `WORD_WIDTH`, 32: input stream word width.
- `ADDR_WIDTH`, 8: command memory address width.
- `BEATS` (localparam) = `CMD_WIDTH/WORD_WIDTH`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `load_start`  in  1  single-cycle pulse that begins a program load at address 0.
- `word_in`  in  `WORD_WIDTH`  stream data.
- `word_valid`  in  1  stream data valid.
- `word_last`  in  1  marks the final word of the program; qualified by `word_valid`.
- `word_ready`  out  1  loader accepts `word_in` this cycle.
- `run`  in  1  single-cycle pulse that releases the core from reset.
- `halt`  in  1  single-cycle pulse that returns the core to reset.
- `proc_reset`  out  1  drives the core's `reset`.
- `write_prog_enable`  out  1  command memory write strobe.
- `cmd_addr`  out  `ADDR_WIDTH`  command memory write address.
- `cmd_data`  out  `CMD_WIDTH`  command memory write data.
- `prog_len`  out  `ADDR_WIDTH+1`  number of commands in the last completed load.
- `busy`  out  1  high in LOAD and WRITE.
- `done`  out  1  high in LOADED.
- `error`  out  1  sticky; cleared by `load_start` or `reset`.

## Operation
- States: IDLE, LOAD, WRITE, LOADED, RUN. All outputs are registered.
- Reset values:
  - State is IDLE; `proc_reset`=1.
  - `write_prog_enable`, `word_ready`, `busy`, `done`, `error` are all 0.
  - `cmd_addr`, `cmd_data`, `prog_len` are 0; the internal beat counter is 0.
- IDLE: `proc_reset`=1, `word_ready`=0. On `load_start`: go to LOAD with beat=0 and addr=0, and clear `error`.
- LOAD: `word_ready`=1.
  - Each handshake (`word_valid`&`word_ready`) places the word MSB-first: beat 0 goes to `[CMD_WIDTH-1 -: WORD_WIDTH]`, beat `BEATS-1` goes to `[WORD_WIDTH-1:0]`.
  - The handshake on beat `BEATS-1` moves the FSM to WRITE and latches `word_last`.
  - `word_last` accepted on any beat other than `BEATS-1`: set `error`, discard the partial command, go to IDLE, no write.
- WRITE: exactly one cycle with `write_prog_enable`=1, `cmd_addr`=addr, `cmd_data`=the assembled command, and `word_ready`=0.
  - If the latched last flag is set: `prog_len`=addr+1, then go to LOADED.
  - Else if addr = 2^`ADDR_WIDTH`-1: set `error` (overflow), then go to IDLE.
  - Else: addr+1, beat=0, then go to LOAD.
- LOADED: `done`=1, `proc_reset`=1.
  - `run` moves the FSM to RUN.
  - `load_start` starts a new load; it takes priority over a simultaneous `run`.
- RUN: `proc_reset`=0, `done`=0.
  - `halt` moves the FSM to IDLE with `proc_reset`=1.
  - `load_start` and `run` are ignored in RUN.
- `run` and `halt` are ignored outside the states listed above. `load_start` is ignored in LOAD and WRITE.
- `reset` asserted mid-load returns everything to reset values. Command memory words already written are not erased.
- `cmd_data` and `cmd_addr` hold their last values when `write_prog_enable`=0.

## Timing
- `load_start` sampled at cycle N: `word_ready`=1 and `busy`=1 from N+1.
- The last-beat handshake at cycle N gives `write_prog_enable`=1 at N+1 only. `word_ready` is 0 at N+1 and returns to 1 at N+2 (LOAD).
- Sustained throughput is one command per `BEATS`+1 cycles (5 cycles at defaults).
- For the final command, `done`=1 and `prog_len` are valid from N+2.
- `run` sampled at cycle N: `proc_reset`=0 from N+1. `halt` sampled at cycle N: `proc_reset`=1 from N+1.
- `word_valid` with `word_ready`=0 is not consumed. The source must hold its data until the handshake.

## Test plan
- Three-command load:
  - Stimulus: 12 words with `word_last` on word 12; command 0 words are 0x81000000, 0x0C000000, 0x00000000, 0x00000000.
  - Response: writes to addr 0, 1, 2. `cmd_data`@0 = 0x81000000_0C000000_00000000_00000000. `prog_len`=3, `done`=1, `proc_reset` stays 1.
- Run/halt:
  - Stimulus: after the load, pulse `run` at cycle N, then `halt` at M.
  - Response: `proc_reset`=0 on N+1..M, back to 1 at M+1; state IDLE.
- Stream stalls:
  - Stimulus: drop `word_valid` for 3 cycles between beats 1 and 2.
  - Response: the assembled command is identical to the no-stall case, and exactly one write pulse occurs.
- Early last:
  - Stimulus: `word_last` on beat 1 of command 0.
  - Response: `error`=1, no `write_prog_enable` pulse, state IDLE. The next `load_start` clears `error`.
- Overflow:
  - Stimulus: `ADDR_WIDTH`=2, 5 commands, no `word_last` until command 4.
  - Response: addr 0–3 written, then `error`=1 after the addr-3 write, then IDLE.
- Reset and priority:
  - Stimulus: `reset` during beat 2 of command 1.
  - Response: all outputs at reset values the next cycle.
  - Stimulus: `load_start` and `run` together in LOADED.
  - Response: LOAD is entered and `proc_reset` stays 1.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: program loader and run controller for one proc core.
//
// Collects a stream of WORD_WIDTH-bit words into CMD_WIDTH-bit commands,
// first word in the most significant slot. Each finished command is written
// to the core's command memory. The core is held in reset while loading and
// is released only by an explicit run request.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   load_start          pulse: begin loading at address 0 (IDLE or LOADED)
//   word_in/valid/last  program word stream; word_ready is the accept side
//   run, halt           pulses: release the core (LOADED) / put it back in reset (RUN)
//   proc_reset          drives the core's reset
//   write_prog_enable   command memory write strobe, with cmd_addr/cmd_data
//   prog_len            number of commands in the last completed load
//   busy, done, error   status: loading / loaded / sticky fault
//
// All outputs are registered. They are computed from the next state, so each
// one lines up with the state it describes.
module prog_loader #(
  parameter int CMD_WIDTH  = 128,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  input  logic                  word_last,
  output logic                  word_ready,
  input  logic                  run,
  input  logic                  halt,
  output logic                  proc_reset,
  output logic                  write_prog_enable,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [CMD_WIDTH-1:0]  cmd_data,
  output logic [ADDR_WIDTH:0]   prog_len,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BEATS  = CMD_WIDTH / WORD_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR  = '1;

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, LOADED, RUN} state_t;

  state_t                  state, state_next;
  logic [BEAT_W-1:0]       beat, beat_next;
  logic [ADDR_WIDTH-1:0]   addr, addr_next;
  logic [CMD_WIDTH-1:0]    asm_buf, asm_buf_next, asm_merged;
  logic                    last_seen, last_seen_next;
  logic [ADDR_WIDTH-1:0]   cmd_addr_next;
  logic [CMD_WIDTH-1:0]    cmd_data_next;
  logic [ADDR_WIDTH:0]     prog_len_next;
  logic                    error_next;
  logic                    handshake;

  // word_ready is registered and high exactly in LOAD.
  assign handshake = word_valid && word_ready;

  // The partial command with the incoming word dropped into the slot for the
  // current beat (beat 0 occupies the top word).
  always_comb begin
    asm_merged = asm_buf;
    for (int b = 0; b < BEATS; b++) begin
      if (beat == BEAT_W'(b)) begin
        asm_merged[(BEATS-1-b)*WORD_WIDTH +: WORD_WIDTH] = word_in;
      end
    end
  end

  always_comb begin
    state_next     = state;
    beat_next      = beat;
    addr_next      = addr;
    asm_buf_next   = asm_buf;
    last_seen_next = last_seen;
    cmd_addr_next  = cmd_addr;
    cmd_data_next  = cmd_data;
    prog_len_next  = prog_len;
    error_next     = error;

    unique case (state)
      IDLE: begin
        if (load_start) begin
          state_next = LOAD;
          beat_next  = '0;
          addr_next  = '0;
          error_next = 1'b0;
        end
      end

      LOAD: begin
        if (handshake) begin
          if (beat == LAST_BEAT) begin
            // Command complete: present it on the write port for one cycle.
            state_next     = WRITE;
            last_seen_next = word_last;
            asm_buf_next   = asm_merged;
            cmd_addr_next  = addr;
            cmd_data_next  = asm_merged;
          end else if (word_last) begin
            // Program ended mid-command: the partial command is dropped.
            state_next = IDLE;
            error_next = 1'b1;
          end else begin
            asm_buf_next = asm_merged;
            beat_next    = beat + 1'b1;
          end
        end
      end

      WRITE: begin
        if (last_seen) begin
          prog_len_next = {1'b0, addr} + (ADDR_WIDTH+1)'(1);
          state_next    = LOADED;
        end else if (addr == MAX_ADDR) begin
          // No address left for the next command.
          state_next = IDLE;
          error_next = 1'b1;
        end else begin
          addr_next  = addr + 1'b1;
          beat_next  = '0;
          state_next = LOAD;
        end
      end

      LOADED: begin
        // A fresh load wins over a simultaneous run.
        if (load_start) begin
          state_next = LOAD;
          beat_next  = '0;
          addr_next  = '0;
          error_next = 1'b0;
        end else if (run) begin
          state_next = RUN;
        end
      end

      RUN: begin
        if (halt) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      beat              <= '0;
      addr              <= '0;
      last_seen         <= 1'b0;
      cmd_addr          <= '0;
      cmd_data          <= '0;
      prog_len          <= '0;
      error             <= 1'b0;
      word_ready        <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      proc_reset        <= 1'b1;
      write_prog_enable <= 1'b0;
    end else begin
      state             <= state_next;
      beat              <= beat_next;
      addr              <= addr_next;
      last_seen         <= last_seen_next;
      cmd_addr          <= cmd_addr_next;
      cmd_data          <= cmd_data_next;
      prog_len          <= prog_len_next;
      error             <= error_next;
      word_ready        <= (state_next == LOAD);
      busy              <= (state_next == LOAD) || (state_next == WRITE);
      done              <= (state_next == LOADED);
      proc_reset        <= (state_next != RUN);
      write_prog_enable <= (state_next == WRITE);
    end
  end

  // Assembly buffer is pure data; every slot is rewritten before it is used.
  always_ff @(posedge clk) begin
    asm_buf <= asm_buf_next;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed and randomized program loads checked
// against a command-level reference model, plus run/halt, priority, reset
// and address-overflow scenarios (the latter on a 2-bit-address instance).
module tb_prog_loader;

  localparam int CW    = 128;
  localparam int WW    = 32;
  localparam int AW    = 8;
  localparam int BEATS = CW / WW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic          reset, load_start, word_valid, word_last, run, halt;
  logic [WW-1:0] word_in;
  logic          word_ready, proc_reset, write_prog_enable, busy, done, error;
  logic [AW-1:0] cmd_addr;
  logic [CW-1:0] cmd_data;
  logic [AW:0]   prog_len;

  // Small instance (ADDR_WIDTH = 2)
  logic          s_load_start, s_word_valid, s_word_last;
  logic [WW-1:0] s_word_in;
  logic          s_word_ready, s_proc_reset, s_wpe, s_busy, s_done, s_error;
  logic [1:0]    s_cmd_addr;
  logic [CW-1:0] s_cmd_data;
  logic [2:0]    s_prog_len;

  prog_loader #(.CMD_WIDTH(CW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .word_in(word_in),
    .word_valid(word_valid), .word_last(word_last), .word_ready(word_ready),
    .run(run), .halt(halt), .proc_reset(proc_reset),
    .write_prog_enable(write_prog_enable), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .prog_len(prog_len), .busy(busy), .done(done),
    .error(error)
  );

  prog_loader #(.CMD_WIDTH(CW), .WORD_WIDTH(WW), .ADDR_WIDTH(2)) dut_small (
    .clk(clk), .reset(reset), .load_start(s_load_start), .word_in(s_word_in),
    .word_valid(s_word_valid), .word_last(s_word_last), .word_ready(s_word_ready),
    .run(1'b0), .halt(1'b0), .proc_reset(s_proc_reset),
    .write_prog_enable(s_wpe), .cmd_addr(s_cmd_addr),
    .cmd_data(s_cmd_data), .prog_len(s_prog_len), .busy(s_busy), .done(s_done),
    .error(s_error)
  );

  // Write monitors
  typedef struct {
    logic [AW-1:0] a;
    logic [CW-1:0] d;
  } wr_t;

  wr_t wq[$];
  wr_t swq[$];

  always @(negedge clk) begin
    wr_t w;
    if (write_prog_enable) begin
      w.a = cmd_addr;
      w.d = cmd_data;
      wq.push_back(w);
    end
    if (s_wpe) begin
      w.a = AW'(s_cmd_addr);
      w.d = s_cmd_data;
      swq.push_back(w);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a program is a word list; command k is words
  // 4k..4k+3 with the first of them in the most significant position.
  logic [WW-1:0] words[$];
  int            last_idx;

  function automatic logic [CW-1:0] model_cmd(input int k);
    logic [CW-1:0] c;
    c = '0;
    for (int j = 0; j < BEATS; j++) begin
      c = c | (CW'(words[k*BEATS+j]) << (WW*(BEATS-1-j)));
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("ready_after_start", word_ready, 1);
    check("busy_after_start", busy, 1);
    check("error_cleared", error, 0);
  endtask

  // Present one word and hold it until it is accepted (bounded wait).
  task automatic send_word(input logic [WW-1:0] w, input bit last, output bit ok);
    int guard;
    word_in    = w;
    word_last  = last;
    word_valid = 1'b1;
    guard      = 0;
    while (!word_ready && guard < 20) begin
      tick();
      guard++;
    end
    ok = word_ready;
    if (!ok) begin
      check("ready_timeout", word_ready, 1);
    end else begin
      tick();
    end
    word_valid = 1'b0;
    word_last  = 1'b0;
  endtask

  // Load the program in words[0..last_idx] and check timing, status and writes.
  task automatic run_load(input int stall_at, input bit rnd_stall);
    int n_exp;
    bit ok;
    wq.delete();
    pulse_load();
    for (int i = 0; i <= last_idx; i++) begin
      int ns;
      ns = (i == stall_at) ? 3 : (rnd_stall ? int'($urandom_range(0, 1)) : 0);
      repeat (ns) tick();
      send_word(words[i], (i == last_idx), ok);
      if (!ok) return;
      if (i % BEATS == BEATS - 1) begin
        check("wpe_after_beat", write_prog_enable, 1);
        check("ready_in_write", word_ready, 0);
        check("write_addr", cmd_addr, i / BEATS);
        tick();
        check("wpe_one_cycle", write_prog_enable, 0);
        if (i == last_idx) begin
          check("done_final", done, 1);
          check("prog_len", prog_len, i / BEATS + 1);
          check("busy_loaded", busy, 0);
          check("core_held", proc_reset, 1);
          check("no_error", error, 0);
        end else begin
          check("ready_back", word_ready, 1);
        end
      end else if (i == last_idx) begin
        check("early_error", error, 1);
        check("early_idle_busy", busy, 0);
        check("early_idle_ready", word_ready, 0);
        check("early_no_write", write_prog_enable, 0);
        check("early_done", done, 0);
      end
    end
    n_exp = (last_idx % BEATS == BEATS - 1) ? last_idx / BEATS + 1 : last_idx / BEATS;
    check("write_count", wq.size(), n_exp);
    for (int k = 0; k < n_exp && k < wq.size(); k++) begin
      check("wq_addr", wq[k].a, k);
      check("wq_data", wq[k].d, model_cmd(k));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    int guard;
    reset = 1'b1; load_start = 1'b0; word_valid = 1'b0; word_last = 1'b0;
    word_in = '0; run = 1'b0; halt = 1'b0;
    s_load_start = 1'b0; s_word_valid = 1'b0; s_word_last = 1'b0; s_word_in = '0;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_proc_reset", proc_reset, 1);
    check("rst_wpe", write_prog_enable, 0);
    check("rst_ready", word_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cmd_addr", cmd_addr, 0);
    check("rst_cmd_data", cmd_data, 0);
    check("rst_prog_len", prog_len, 0);

    // Three-command program
    words = {32'h81000000, 32'h0C000000, 32'h00000000, 32'h00000000,
             32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0,
             32'hDEADBEEF, 32'h00000001, 32'h80000000, 32'hCAFEF00D};
    last_idx = 11;
    run_load(-1, 1'b0);
    if (wq.size() > 0) check("cmd0_literal", wq[0].d, 128'h81000000_0C000000_00000000_00000000);

    // Same program with a 3-cycle stall before beat 2
    run_load(2, 1'b0);

    // Run / halt
    run = 1'b1; tick(); run = 1'b0;
    check("run_release", proc_reset, 0);
    check("run_done_low", done, 0);
    load_start = 1'b1; tick(); load_start = 1'b0;
    check("load_ignored_in_run", busy, 0);
    check("still_running", proc_reset, 0);
    repeat (3) tick();
    check("running_later", proc_reset, 0);
    halt = 1'b1; tick(); halt = 1'b0;
    check("halt_reset", proc_reset, 1);
    check("halt_idle", {busy, done, word_ready}, 0);
    run = 1'b1; tick(); run = 1'b0;
    check("run_ignored_idle", proc_reset, 1);

    // Randomized programs, some ending early
    for (int t = 0; t < 8; t++) begin
      int  ncmd;
      bit  early;
      ncmd  = $urandom_range(1, 4);
      early = ($urandom_range(0, 3) == 0);
      words.delete();
      for (int i = 0; i < ncmd * BEATS; i++) words.push_back($urandom);
      if (early) last_idx = $urandom_range(0, ncmd - 1) * BEATS + $urandom_range(0, BEATS - 2);
      else       last_idx = ncmd * BEATS - 1;
      run_load(-1, 1'b1);
    end

    // load_start beats run in LOADED
    words.delete();
    for (int i = 0; i < BEATS; i++) words.push_back($urandom);
    last_idx = BEATS - 1;
    run_load(-1, 1'b0);
    load_start = 1'b1; run = 1'b1; tick(); load_start = 1'b0; run = 1'b0;
    check("prio_load", word_ready, 1);
    check("prio_busy", busy, 1);
    check("prio_core_held", proc_reset, 1);
    words.delete();
    for (int i = 0; i < 2 * BEATS; i++) words.push_back($urandom);
    last_idx = 2 * BEATS - 1;
    run_load(-1, 1'b1);

    // Reset during beat 2 of command 1
    pulse_load();
    for (int i = 0; i < BEATS + 2; i++) send_word($urandom, 1'b0, ok);
    word_in = $urandom; word_valid = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; word_valid = 1'b0;
    check("mid_rst_proc_reset", proc_reset, 1);
    check("mid_rst_wpe", write_prog_enable, 0);
    check("mid_rst_ready", word_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_cmd_addr", cmd_addr, 0);
    check("mid_rst_cmd_data", cmd_data, 0);
    check("mid_rst_prog_len", prog_len, 0);

    // Loading works again after reset
    words.delete();
    for (int i = 0; i < 3 * BEATS; i++) words.push_back($urandom);
    last_idx = 3 * BEATS - 1;
    run_load(-1, 1'b1);

    // Overflow on the 4-entry instance
    swq.delete();
    words.delete();
    s_load_start = 1'b1; tick(); s_load_start = 1'b0;
    for (int i = 0; i < 4 * BEATS; i++) begin
      s_word_in = $urandom;
      words.push_back(s_word_in);
      s_word_valid = 1'b1;
      guard = 0;
      while (!s_word_ready && guard < 20) begin
        tick();
        guard++;
      end
      if (!s_word_ready) begin
        check("small_ready_timeout", s_word_ready, 1);
        break;
      end
      tick();
      s_word_valid = 1'b0;
    end
    check("ovf_last_write", s_wpe, 1);
    check("ovf_last_addr", s_cmd_addr, 3);
    check("ovf_no_err_yet", s_error, 0);
    tick();
    check("ovf_error", s_error, 1);
    check("ovf_idle", {s_busy, s_done, s_word_ready}, 0);
    check("ovf_core_held", s_proc_reset, 1);
    s_word_in = $urandom; s_word_valid = 1'b1;
    repeat (3) tick();
    check("ovf_no_accept", s_word_ready, 0);
    s_word_valid = 1'b0;
    check("ovf_write_count", swq.size(), 4);
    for (int k = 0; k < 4 && k < swq.size(); k++) begin
      check("ovf_addr", swq[k].a, k);
      check("ovf_data", swq[k].d, model_cmd(k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
